// File: rtl/rom_loader_if.sv
//------------------------------------------------------------------------------
// rom_loader_if : byte-stream input and memory write port of the ROM loader
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface rom_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_we;
    logic        BW;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_addr, mem_din, mem_we, BW, busy, done, err
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_addr, mem_din, mem_we, BW, busy, done, err
    );
endinterface

`default_nettype wire

// File: rtl/rom_loader.sv
//------------------------------------------------------------------------------
// rom_loader : turns framed load records on a byte stream into program-memory
//              writes, with range/alignment checking and busy/done/err status
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rom_loader #(
    parameter logic [15:0] BOUND_U = 16'hFFFF,
    parameter logic [15:0] BOUND_L = 16'hC000
) (
    input wire logic        clk,
    input wire logic        rst_n,
    rom_loader_if.slave     io_bus
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ADDR_L = 4'd1,
        ST_ADDR_H = 4'd2,
        ST_CNT_L  = 4'd3,
        ST_CNT_H  = 4'd4,
        ST_CHECK  = 4'd5,
        ST_DATA_L = 4'd6,
        ST_DATA_H = 4'd7,
        ST_WRITE  = 4'd8,
        ST_DRAIN  = 4'd9,
        ST_DONE   = 4'd10
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_addr;
    logic [15:0] r_cnt;
    logic        r_bm;
    logic [7:0]  r_low;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_din;
    logic        r_err;

    logic        w_ready;
    logic        w_xfer;
    logic [14:0] w_n;
    logic [15:0] w_drain_len;
    logic [16:0] w_span;
    logic [16:0] w_step;
    logic [16:0] w_end;
    logic        w_chk_err;

    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE, ST_ADDR_H, ST_CNT_L, ST_CNT_H,
            ST_DATA_L, ST_DATA_H, ST_DRAIN: w_ready = 1'b1;
            default:                        w_ready = 1'b0;
        endcase
    end

    assign w_xfer = w_ready & io_bus.rx_valid & rst_n;

    // Range check in 17 bits so a record running past 16'hFFFF cannot wrap.
    assign w_n         = r_cnt[14:0];
    assign w_drain_len = r_bm ? {1'b0, w_n} : {w_n, 1'b0};
    assign w_span      = {1'b0, w_drain_len};
    assign w_step      = r_bm ? 17'd1 : 17'd2;
    assign w_end       = {1'b0, r_addr} + w_span - w_step;
    assign w_chk_err   = (r_addr < BOUND_L)
                       | (~r_bm & r_addr[0])
                       | ((w_n != 15'd0) & (w_end > {1'b0, BOUND_U}));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_xfer) w_state_next = ST_ADDR_H;
            ST_ADDR_H: if (w_xfer) w_state_next = ST_CNT_L;
            ST_CNT_L:  if (w_xfer) w_state_next = ST_CNT_H;
            ST_CNT_H:  if (w_xfer) w_state_next = ST_CHECK;
            ST_CHECK: begin
                if (w_chk_err)
                    w_state_next = (w_drain_len == 16'd0) ? ST_IDLE : ST_DRAIN;
                else if (w_n == 15'd0)
                    w_state_next = ST_DONE;
                else
                    w_state_next = r_bm ? ST_DATA_H : ST_DATA_L;
            end
            ST_DATA_L: if (w_xfer) w_state_next = ST_DATA_H;
            ST_DATA_H: if (w_xfer) w_state_next = ST_WRITE;
            ST_WRITE: begin
                if (r_cnt == 16'd1)
                    w_state_next = ST_DONE;
                else
                    w_state_next = r_bm ? ST_DATA_H : ST_DATA_L;
            end
            ST_DRAIN:  if (w_xfer && r_cnt == 16'd1) w_state_next = ST_IDLE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= 16'h0000;
            r_cnt      <= 16'h0000;
            r_bm       <= 1'b0;
            r_low      <= 8'h00;
            r_mem_addr <= 16'h0000;
            r_mem_din  <= 16'h0000;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: if (w_xfer) begin
                    r_addr[7:0] <= io_bus.rx_data;
                    r_err       <= 1'b0;
                end
                ST_ADDR_H: if (w_xfer) r_addr[15:8] <= io_bus.rx_data;
                ST_CNT_L:  if (w_xfer) r_cnt[7:0]   <= io_bus.rx_data;
                ST_CNT_H: if (w_xfer) begin
                    r_cnt[15:8] <= {1'b0, io_bus.rx_data[6:0]};
                    r_bm        <= io_bus.rx_data[7];
                end
                ST_CHECK: if (w_chk_err) begin
                    r_cnt <= w_drain_len;
                    r_err <= 1'b1;
                end
                ST_DATA_L: if (w_xfer) r_low <= io_bus.rx_data;
                ST_DATA_H: if (w_xfer) begin
                    r_mem_addr <= r_addr;
                    r_mem_din  <= r_bm ? {8'h00, io_bus.rx_data} : {io_bus.rx_data, r_low};
                end
                ST_WRITE: begin
                    r_addr <= r_addr + w_step[15:0];
                    r_cnt  <= r_cnt - 16'd1;
                end
                ST_DRAIN: if (w_xfer) r_cnt <= r_cnt - 16'd1;
                default: ;
            endcase
        end
    end

    // rx_ready is gated by reset so nothing is offered as accepted while held in reset.
    assign io_bus.rx_ready = w_ready & rst_n;
    assign io_bus.mem_we   = (r_state == ST_WRITE);
    assign io_bus.BW       = (r_state == ST_WRITE) & r_bm;
    assign io_bus.mem_addr = r_mem_addr;
    assign io_bus.mem_din  = r_mem_din;
    assign io_bus.busy     = (r_state != ST_IDLE);
    assign io_bus.done     = (r_state == ST_DONE);
    assign io_bus.err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rom_loader.sv
//------------------------------------------------------------------------------
// tb_rom_loader : directed self-checking bench for rom_loader
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rom_loader;

    logic clk;
    logic rst_n;

    rom_loader_if ifc ();

    rom_loader #(
        .BOUND_U (16'hFFFF),
        .BOUND_L (16'hC000)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [15:0] wa [64];
    logic [15:0] wd [64];
    logic        wb [64];
    int          wc [64];
    int          nw     = 0;
    int          ndone  = 0;
    int          dcyc   = 0;
    int          nboth  = 0;

    logic [7:0] fq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifc.mem_we && nw < 64) begin
            wa[nw] = ifc.mem_addr;
            wd[nw] = ifc.mem_din;
            wb[nw] = ifc.BW;
            wc[nw] = cyc;
            nw     = nw + 1;
        end
        if (ifc.done) begin
            ndone = ndone + 1;
            dcyc  = cyc;
        end
        if (ifc.done && ifc.err) nboth = nboth + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int maxgap);
        int t;
        t = 0;
        repeat ($urandom_range(0, maxgap)) @(negedge clk);
        @(negedge clk);
        ifc.rx_data  = b;
        ifc.rx_valid = 1'b1;
        while (!ifc.rx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ifc.rx_ready) begin
            chk("rx_ready_timeout", {31'd0, ifc.rx_ready}, 32'd1);
            ifc.rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            ifc.rx_valid = 1'b0;
        end
    endtask

    task automatic send_fq(input int maxgap);
        foreach (fq[i]) send(fq[i], maxgap);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (ifc.busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", {31'd0, ifc.busy}, 32'd0);
    endtask

    task automatic word_test(input string tag, input int maxgap);
        int b0, d0;
        b0 = nw;
        d0 = ndone;
        fq = '{8'h00, 8'hC0, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
        send_fq(maxgap);
        wait_idle();
        chk({tag, "_nwrites"}, nw - b0, 2);
        chk({tag, "_a0"}, {16'd0, wa[b0]},   32'h0000C000);
        chk({tag, "_d0"}, {16'd0, wd[b0]},   32'h00001234);
        chk({tag, "_bw0"}, {31'd0, wb[b0]},  32'd0);
        chk({tag, "_a1"}, {16'd0, wa[b0+1]}, 32'h0000C002);
        chk({tag, "_d1"}, {16'd0, wd[b0+1]}, 32'h00005678);
        chk({tag, "_bw1"}, {31'd0, wb[b0+1]}, 32'd0);
        chk({tag, "_done"}, ndone - d0, 1);
        chk({tag, "_done_lat"}, dcyc - wc[b0+1], 1);
        chk({tag, "_err"}, {31'd0, ifc.err}, 32'd0);
    endtask

    initial begin
        int b0, d0;
        rst_n        = 1'b0;
        ifc.rx_data  = 8'h00;
        ifc.rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_ready", {31'd0, ifc.rx_ready}, 32'd0);
        chk("rst_busy",     {31'd0, ifc.busy},     32'd0);
        chk("rst_we",       {31'd0, ifc.mem_we},   32'd0);
        chk("rst_bw",       {31'd0, ifc.BW},       32'd0);
        chk("rst_addr",     {16'd0, ifc.mem_addr}, 32'd0);
        chk("rst_din",      {16'd0, ifc.mem_din},  32'd0);
        chk("rst_done",     {31'd0, ifc.done},     32'd0);
        chk("rst_err",      {31'd0, ifc.err},      32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rx_ready", {31'd0, ifc.rx_ready}, 32'd1);

        // Word load, back to back.
        word_test("t1", 0);

        // Byte load.
        b0 = nw; d0 = ndone;
        fq = '{8'h10, 8'hC0, 8'h03, 8'h80, 8'hAA, 8'hBB, 8'hCC};
        send_fq(0);
        wait_idle();
        chk("t2_nwrites", nw - b0, 3);
        chk("t2_a0", {16'd0, wa[b0]},   32'h0000C010);
        chk("t2_d0", {16'd0, wd[b0]},   32'h000000AA);
        chk("t2_a1", {16'd0, wa[b0+1]}, 32'h0000C011);
        chk("t2_d1", {16'd0, wd[b0+1]}, 32'h000000BB);
        chk("t2_a2", {16'd0, wa[b0+2]}, 32'h0000C012);
        chk("t2_d2", {16'd0, wd[b0+2]}, 32'h000000CC);
        chk("t2_bw", {29'd0, wb[b0], wb[b0+1], wb[b0+2]}, 32'd7);
        chk("t2_done", ndone - d0, 1);

        // Range overflow past FFFF: rejected, payload drained.
        b0 = nw; d0 = ndone;
        fq = '{8'hFE, 8'hFF, 8'h02, 8'h00};
        send_fq(0);
        repeat (2) @(negedge clk);
        chk("t3_err_in_drain", {31'd0, ifc.err}, 32'd1);
        fq = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_fq(0);
        wait_idle();
        chk("t3_nwrites", nw - b0, 0);
        chk("t3_err_held", {31'd0, ifc.err}, 32'd1);
        chk("t3_no_done", ndone - d0, 0);

        // Range ending exactly at FFFF is legal.
        b0 = nw; d0 = ndone;
        fq = '{8'hFE, 8'hFF, 8'h01, 8'h00, 8'hEF, 8'hBE};
        send_fq(0);
        wait_idle();
        chk("t3b_nwrites", nw - b0, 1);
        chk("t3b_a0", {16'd0, wa[b0]}, 32'h0000FFFE);
        chk("t3b_d0", {16'd0, wd[b0]}, 32'h0000BEEF);
        chk("t3b_done", ndone - d0, 1);
        chk("t3b_err", {31'd0, ifc.err}, 32'd0);

        // Odd word address, then address below BOUND_L.
        b0 = nw; d0 = ndone;
        fq = '{8'h01, 8'hC0, 8'h01, 8'h00, 8'h55, 8'h66};
        send_fq(0);
        wait_idle();
        chk("t4_odd_err", {31'd0, ifc.err}, 32'd1);
        fq = '{8'h00, 8'h80, 8'h01, 8'h00, 8'h77, 8'h88};
        send_fq(0);
        wait_idle();
        chk("t4_low_err", {31'd0, ifc.err}, 32'd1);
        chk("t4_nwrites", nw - b0, 0);
        chk("t4_no_done", ndone - d0, 0);

        // N=0 frame: first byte clears err, done without writes.
        b0 = nw; d0 = ndone;
        send(8'h00, 0);
        @(negedge clk);
        chk("t5_err_cleared", {31'd0, ifc.err}, 32'd0);
        fq = '{8'hC0, 8'h00, 8'h00};
        send_fq(0);
        wait_idle();
        chk("t5_nwrites", nw - b0, 0);
        chk("t5_done", ndone - d0, 1);

        // Word load with random rx_valid gaps.
        word_test("t5g", 3);

        // Reset after the first payload byte.
        b0 = nw; d0 = ndone;
        fq = '{8'h00, 8'hC0, 8'h02, 8'h00, 8'h34};
        send_fq(0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_busy",     {31'd0, ifc.busy},     32'd0);
        chk("t6_we",       {31'd0, ifc.mem_we},   32'd0);
        chk("t6_addr",     {16'd0, ifc.mem_addr}, 32'd0);
        chk("t6_din",      {16'd0, ifc.mem_din},  32'd0);
        chk("t6_rx_ready", {31'd0, ifc.rx_ready}, 32'd0);
        chk("t6_err",      {31'd0, ifc.err},      32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_nwrites", nw - b0, 0);
        chk("t6_no_done", ndone - d0, 0);
        word_test("t6f", 1);

        chk("err_done_overlap", nboth, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
